// File: rtl/bean_ctrl_pkg.sv
// Shared control encodings for the multicycle RV32I core: opcodes, FSM states,
// datapath select/mode encodings and the strobe bundle driven by the controller.
package bean_ctrl_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;

  typedef logic [2:0] state_t;
  localparam state_t ST_INIT    = 3'd0;
  localparam state_t ST_FETCH   = 3'd1;
  localparam state_t ST_EXEC    = 3'd2;
  localparam state_t ST_LOAD_WB = 3'd3;
  localparam state_t ST_HALT    = 3'd4;
  localparam state_t ST_TRAP    = 3'd5;

  localparam logic [1:0] REG_SEL_MEM = 2'b00;
  localparam logic [1:0] REG_SEL_ALU = 2'b01;
  localparam logic [1:0] REG_SEL_PC4 = 2'b10;
  localparam logic [1:0] REG_SEL_IMM = 2'b11;

  localparam logic [1:0] PC_SEL_PC4 = 2'b00;
  localparam logic [1:0] PC_SEL_IMM = 2'b01;
  localparam logic [1:0] PC_SEL_ALU = 2'b10;

  localparam logic [2:0] IMM_NONE = 3'b000;
  localparam logic [2:0] IMM_S    = 3'b001;
  localparam logic [2:0] IMM_B    = 3'b010;
  localparam logic [2:0] IMM_I    = 3'b011;
  localparam logic [2:0] IMM_U    = 3'b100;
  localparam logic [2:0] IMM_J    = 3'b101;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1001;

  localparam logic [2:0] MEM_WORD = 3'b010;

  typedef struct packed {
    logic       reg_we;
    logic       rs1_sel;
    logic       rs2_sel;
    logic       addrs_sel;
    logic       pc_en;
    logic       instr_en;
    logic       alu_mem_en;
    logic       mem_in_en;
    logic       mem_we;
    logic [1:0] reg_sel;
    logic [1:0] pc_sel;
    logic [2:0] imm_sel;
    logic [3:0] alu_mode;
    logic [2:0] mem_mode;
  } ctrl_t;

  // Branch condition selected by funct3; the two unused encodings never take.
  function automatic logic branch_taken(input logic [2:0] funct3, input logic eq,
                                        input logic lt, input logic ltu);
    logic taken;
    case (funct3)
      3'b000:  taken = eq;
      3'b001:  taken = !eq;
      3'b100:  taken = lt;
      3'b101:  taken = !lt;
      3'b110:  taken = ltu;
      3'b111:  taken = !ltu;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps funct3/funct7[5] of OP and OP-IMM instructions to an ALU operation;
// every other opcode gets ADD (address and PC-relative arithmetic).
module alu_decoder
  import bean_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_mode
);

  logic is_op;
  logic is_arith;

  assign is_op    = (opcode == OPC_OP);
  assign is_arith = is_op || (opcode == OPC_OP_IMM);

  always_comb begin
    alu_mode = ALU_ADD;
    if (is_arith) begin
      case (funct3)
        // funct7[5] of an immediate-form ADDI is immediate data, not SUB.
        3'b000:  alu_mode = (is_op && funct7_5) ? ALU_SUB : ALU_ADD;
        3'b001:  alu_mode = ALU_SLL;
        3'b010:  alu_mode = ALU_SLT;
        3'b011:  alu_mode = ALU_SLTU;
        3'b100:  alu_mode = ALU_XOR;
        3'b101:  alu_mode = funct7_5 ? ALU_SRA : ALU_SRL;
        3'b110:  alu_mode = ALU_OR;
        default: alu_mode = ALU_AND;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Control FSM for the multicycle RV32I datapath: FETCH/EXEC/LOAD_WB sequencing,
// strobe decode, retired-instruction counter, halt handshake and illegal-opcode trap.
module multicycle_control_unit
  import bean_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             cmp_EQ,
  input  logic             cmp_LT,
  input  logic             cmp_LTU,
  input  logic             halt_REQ,
  output logic             reg_WE,
  output logic             rs1_SEL,
  output logic             rs2_SEL,
  output logic             addrs_SEL,
  output logic             pc_EN,
  output logic             instr_EN,
  output logic             ALU_mem_EN,
  output logic             mem_in_EN,
  output logic             mem_WE,
  output logic [1:0]       reg_SEL,
  output logic [1:0]       pc_SEL,
  output logic [2:0]       imm_SEL,
  output logic [2:0]       mem_MODE,
  output logic [3:0]       ALU_MODE,
  output logic             halted,
  output logic             illegal_INSTR,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state_dbg
);

  state_t     state;
  state_t     state_nxt;
  ctrl_t      ctrl;
  logic       retire;
  logic       trap_entry;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [3:0] dec_alu_mode;
  logic       unused_instr_bits;

  assign opcode            = instr[6:0];
  assign funct3            = instr[14:12];
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  alu_decoder u_alu_decoder (
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7_5 (instr[30]),
    .alu_mode (dec_alu_mode)
  );

  always_comb begin
    ctrl       = '0;
    state_nxt  = state;
    retire     = 1'b0;
    trap_entry = 1'b0;
    case (state)
      ST_INIT: state_nxt = ST_FETCH;
      ST_FETCH: begin
        ctrl.addrs_sel = 1'b1;
        ctrl.instr_en  = 1'b1;
        ctrl.mem_in_en = 1'b1;
        ctrl.mem_mode  = MEM_WORD;
        state_nxt      = ST_EXEC;
      end
      ST_EXEC: begin
        retire     = 1'b1;
        ctrl.pc_en = 1'b1;
        case (opcode)
          OPC_OP: begin
            ctrl.reg_sel  = REG_SEL_ALU;
            ctrl.reg_we   = 1'b1;
            ctrl.alu_mode = dec_alu_mode;
          end
          OPC_OP_IMM: begin
            ctrl.rs2_sel  = 1'b1;
            ctrl.imm_sel  = IMM_I;
            ctrl.reg_sel  = REG_SEL_ALU;
            ctrl.reg_we   = 1'b1;
            ctrl.alu_mode = dec_alu_mode;
          end
          OPC_LUI: begin
            ctrl.reg_sel = REG_SEL_IMM;
            ctrl.imm_sel = IMM_U;
            ctrl.reg_we  = 1'b1;
          end
          OPC_AUIPC: begin
            ctrl.rs1_sel  = 1'b1;
            ctrl.rs2_sel  = 1'b1;
            ctrl.imm_sel  = IMM_U;
            ctrl.alu_mode = ALU_ADD;
            ctrl.reg_sel  = REG_SEL_ALU;
            ctrl.reg_we   = 1'b1;
          end
          OPC_JAL: begin
            ctrl.reg_sel = REG_SEL_PC4;
            ctrl.reg_we  = 1'b1;
            ctrl.pc_sel  = PC_SEL_IMM;
            ctrl.imm_sel = IMM_J;
          end
          OPC_JALR: begin
            ctrl.reg_sel  = REG_SEL_PC4;
            ctrl.reg_we   = 1'b1;
            ctrl.rs2_sel  = 1'b1;
            ctrl.imm_sel  = IMM_I;
            ctrl.alu_mode = ALU_ADD;
            ctrl.pc_sel   = PC_SEL_ALU;
          end
          OPC_BRANCH: begin
            ctrl.imm_sel = IMM_B;
            ctrl.pc_sel  = branch_taken(funct3, cmp_EQ, cmp_LT, cmp_LTU) ? PC_SEL_IMM : PC_SEL_PC4;
          end
          OPC_STORE: begin
            ctrl.rs2_sel    = 1'b1;
            ctrl.imm_sel    = IMM_S;
            ctrl.alu_mode   = ALU_ADD;
            ctrl.alu_mem_en = 1'b1;
            ctrl.mem_we     = 1'b1;
            ctrl.mem_mode   = funct3;
          end
          OPC_LOAD: begin
            // Address phase only; the PC advances once the data is written back.
            ctrl.pc_en      = 1'b0;
            ctrl.rs2_sel    = 1'b1;
            ctrl.imm_sel    = IMM_I;
            ctrl.alu_mode   = ALU_ADD;
            ctrl.alu_mem_en = 1'b1;
            ctrl.mem_in_en  = 1'b1;
            ctrl.mem_mode   = funct3;
            retire          = 1'b0;
            state_nxt       = ST_LOAD_WB;
          end
          default: begin
            ctrl.pc_en = 1'b0;
            retire     = 1'b0;
            trap_entry = 1'b1;
            state_nxt  = ST_TRAP;
          end
        endcase
      end
      ST_LOAD_WB: begin
        ctrl.reg_sel = REG_SEL_MEM;
        ctrl.reg_we  = 1'b1;
        ctrl.pc_en   = 1'b1;
        ctrl.pc_sel  = PC_SEL_PC4;
        retire       = 1'b1;
      end
      ST_HALT: begin
        if (!halt_REQ) state_nxt = ST_FETCH;
      end
      ST_TRAP: state_nxt = ST_TRAP;
      default: state_nxt = ST_INIT;
    endcase
    // Halt is only honoured at an instruction boundary.
    if (retire) state_nxt = halt_REQ ? ST_HALT : ST_FETCH;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_INIT;
      instret       <= '0;
      illegal_INSTR <= 1'b0;
    end else begin
      state <= state_nxt;
      if (retire) instret <= instret + CNT_W'(1);
      if (trap_entry) illegal_INSTR <= 1'b1;
    end
  end

  assign reg_WE     = ctrl.reg_we;
  assign rs1_SEL    = ctrl.rs1_sel;
  assign rs2_SEL    = ctrl.rs2_sel;
  assign addrs_SEL  = ctrl.addrs_sel;
  assign pc_EN      = ctrl.pc_en;
  assign instr_EN   = ctrl.instr_en;
  assign ALU_mem_EN = ctrl.alu_mem_en;
  assign mem_in_EN  = ctrl.mem_in_en;
  assign mem_WE     = ctrl.mem_we;
  assign reg_SEL    = ctrl.reg_sel;
  assign pc_SEL     = ctrl.pc_sel;
  assign imm_SEL    = ctrl.imm_sel;
  assign mem_MODE   = ctrl.mem_mode;
  assign ALU_MODE   = ctrl.alu_mode;
  assign halted     = (state == ST_HALT);
  assign state_dbg  = state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit: instruction-level reference model
// feeding an expected-output queue, checked every cycle by an independent monitor.
module tb_multicycle_control_unit;

  localparam int CNT_W = 6;
  localparam int W     = 25 + CNT_W;

  typedef struct packed {
    logic reg_we, rs1_sel, rs2_sel, addrs_sel, pc_en, instr_en, alu_mem_en, mem_in_en, mem_we;
    logic [1:0] reg_sel, pc_sel;
    logic [2:0] imm_sel, mem_mode;
    logic [3:0] alu_mode;
    logic halted, illegal;
    logic [CNT_W-1:0] instret;
  } obs_t;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic reset;
  logic [31:0] instr;
  logic cmp_EQ, cmp_LT, cmp_LTU, halt_REQ;
  logic reg_WE, rs1_SEL, rs2_SEL, addrs_SEL, pc_EN, instr_EN, ALU_mem_EN, mem_in_EN, mem_WE;
  logic [1:0] reg_SEL, pc_SEL;
  logic [2:0] imm_SEL, mem_MODE;
  logic [3:0] ALU_MODE;
  logic halted, illegal_INSTR;
  logic [CNT_W-1:0] instret;
  logic [2:0] state_dbg;

  always #5 clk = ~clk;

  multicycle_control_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .instr(instr),
    .cmp_EQ(cmp_EQ), .cmp_LT(cmp_LT), .cmp_LTU(cmp_LTU), .halt_REQ(halt_REQ),
    .reg_WE(reg_WE), .rs1_SEL(rs1_SEL), .rs2_SEL(rs2_SEL), .addrs_SEL(addrs_SEL),
    .pc_EN(pc_EN), .instr_EN(instr_EN), .ALU_mem_EN(ALU_mem_EN), .mem_in_EN(mem_in_EN),
    .mem_WE(mem_WE), .reg_SEL(reg_SEL), .pc_SEL(pc_SEL), .imm_SEL(imm_SEL),
    .mem_MODE(mem_MODE), .ALU_MODE(ALU_MODE), .halted(halted),
    .illegal_INSTR(illegal_INSTR), .instret(instret), .state_dbg(state_dbg)
  );

  // ---------------- reference model state ----------------
  logic [W-1:0]     exp_q[$];
  int               n_checks = 0;
  int               n_fail   = 0;
  logic [CNT_W-1:0] m_instret;
  logic             m_illegal;
  logic [3:0]       alu_of_f3 [8];
  logic [6:0]       legal_ops [9];

  function automatic obs_t base_obs();
    obs_t o;
    o         = '0;
    o.instret = m_instret;
    o.illegal = m_illegal;
    return o;
  endfunction

  function automatic logic is_legal(input logic [6:0] opc);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < 9; k++) if (legal_ops[k] == opc) hit = 1'b1;
    return hit;
  endfunction

  // Control word an instruction needs in its execute cycle; cmp = {ltu, lt, eq}.
  function automatic obs_t ref_exec(input logic [31:0] i, input logic [2:0] cmp);
    obs_t o;
    logic [2:0] f3;
    logic [3:0] arith;
    logic taken;
    o     = base_obs();
    f3    = i[14:12];
    arith = alu_of_f3[f3];
    if (f3 == 3'd5 && i[30]) arith = 4'd7;
    case (f3)
      3'd0: taken = cmp[0];
      3'd1: taken = !cmp[0];
      3'd4: taken = cmp[1];
      3'd5: taken = !cmp[1];
      3'd6: taken = cmp[2];
      3'd7: taken = !cmp[2];
      default: taken = 1'b0;
    endcase
    case (i[6:0])
      7'b0110011: begin
        if (f3 == 3'd0 && i[30]) arith = 4'd1;
        o.reg_we = 1; o.reg_sel = 2'b01; o.alu_mode = arith; o.pc_en = 1;
      end
      7'b0010011: begin
        o.reg_we = 1; o.reg_sel = 2'b01; o.rs2_sel = 1; o.imm_sel = 3'd3; o.alu_mode = arith; o.pc_en = 1;
      end
      7'b0110111: begin o.reg_we = 1; o.reg_sel = 2'b11; o.imm_sel = 3'd4; o.pc_en = 1; end
      7'b0010111: begin
        o.reg_we = 1; o.reg_sel = 2'b01; o.rs1_sel = 1; o.rs2_sel = 1; o.imm_sel = 3'd4; o.pc_en = 1;
      end
      7'b1101111: begin o.reg_we = 1; o.reg_sel = 2'b10; o.pc_sel = 2'b01; o.imm_sel = 3'd5; o.pc_en = 1; end
      7'b1100111: begin
        o.reg_we = 1; o.reg_sel = 2'b10; o.rs2_sel = 1; o.imm_sel = 3'd3; o.pc_sel = 2'b10; o.pc_en = 1;
      end
      7'b1100011: begin o.imm_sel = 3'd2; o.pc_sel = taken ? 2'b01 : 2'b00; o.pc_en = 1; end
      7'b0100011: begin
        o.rs2_sel = 1; o.imm_sel = 3'd1; o.alu_mem_en = 1; o.mem_we = 1; o.mem_mode = f3; o.pc_en = 1;
      end
      7'b0000011: begin
        o.rs2_sel = 1; o.imm_sel = 3'd3; o.alu_mem_en = 1; o.mem_in_en = 1; o.mem_mode = f3;
      end
      default: ;
    endcase
    return o;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_obs(input obs_t e);
    exp_q.push_back(W'(e));
  endtask

  task automatic do_reset(input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      next_cycle();
      reset = 1'b1;
      m_instret = '0;
      m_illegal = 1'b0;
      expect_obs(base_obs());
    end
    next_cycle();
    reset = 1'b0;
    expect_obs(base_obs());
  endtask

  task automatic fetch_cycle();
    obs_t e;
    next_cycle();
    instr    = $urandom;
    halt_REQ = 1'($urandom_range(0, 1));
    {cmp_LTU, cmp_LT, cmp_EQ} = 3'($urandom_range(0, 7));
    e           = base_obs();
    e.addrs_sel = 1; e.instr_en = 1; e.mem_in_en = 1; e.mem_mode = 3'b010;
    expect_obs(e);
  endtask

  task automatic run_instr(input logic [31:0] i, input logic [2:0] cmp, input logic hreq,
                           input int hold);
    obs_t e;
    logic is_load;
    is_load = (i[6:0] == 7'b0000011);
    fetch_cycle();
    next_cycle();
    instr = i;
    {cmp_LTU, cmp_LT, cmp_EQ} = cmp;
    halt_REQ = is_load ? 1'($urandom_range(0, 1)) : hreq;
    expect_obs(ref_exec(i, cmp));
    if (!is_legal(i[6:0])) begin
      m_illegal = 1'b1;
      return;
    end
    if (is_load) begin
      next_cycle();
      halt_REQ = hreq;
      {cmp_LTU, cmp_LT, cmp_EQ} = 3'($urandom_range(0, 7));
      e = base_obs();
      e.reg_we = 1; e.pc_en = 1;
      expect_obs(e);
    end
    m_instret = m_instret + 1'b1;
    if (hreq) begin
      e        = base_obs();
      e.halted = 1;
      for (int k = 0; k < hold; k++) begin
        next_cycle();
        halt_REQ = 1'b1;
        expect_obs(e);
      end
      next_cycle();
      halt_REQ = 1'b0;
      expect_obs(e);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [W-1:0] act_vec;
  logic [W-1:0] exp_vec;
  assign act_vec = {reg_WE, rs1_SEL, rs2_SEL, addrs_SEL, pc_EN, instr_EN, ALU_mem_EN, mem_in_EN,
                    mem_WE, reg_SEL, pc_SEL, imm_SEL, mem_MODE, ALU_MODE, halted, illegal_INSTR,
                    instret};

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_vec = exp_q.pop_front();
      n_checks++;
      if (act_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL ctrl_vec t=%0t got=%h expected=%h (state_dbg=%0d)", $time, act_vec,
                 exp_vec, state_dbg);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] ri;
    reset = 1'b1; instr = '0; halt_REQ = 1'b0;
    cmp_EQ = 1'b0; cmp_LT = 1'b0; cmp_LTU = 1'b0;
    m_instret = '0; m_illegal = 1'b0;
    alu_of_f3 = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    legal_ops = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111,
                  7'b1100111, 7'b1100011, 7'b0100011, 7'b0000011};

    do_reset(3);
    run_instr(32'h00800513, 3'b000, 1'b0, 0);
    run_instr(32'h00b52023, 3'($urandom_range(0, 7)), 1'b0, 0);
    run_instr(32'h00452603, 3'($urandom_range(0, 7)), 1'b1, 2);
    run_instr(32'h00000463, 3'b001, 1'b0, 0);
    run_instr(32'h00000463, 3'b000, 1'b0, 0);

    for (int n = 0; n < 150; n++) begin
      ri      = $urandom;
      ri[6:0] = legal_ops[$urandom_range(0, 8)];
      run_instr(ri, 3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0),
                $urandom_range(0, 3));
    end

    // Reset arrives in the execute cycle of a store.
    fetch_cycle();
    next_cycle();
    instr    = 32'h00b52023;
    halt_REQ = 1'b0;
    #1;
    n_checks++;
    if (mem_WE !== 1'b1) begin
      n_fail++;
      $display("FAIL store_exec_we got=%b expected=1", mem_WE);
    end
    #1;
    reset     = 1'b1;
    m_instret = '0;
    m_illegal = 1'b0;
    expect_obs(base_obs());
    do_reset(1);

    run_instr(32'h00800513, 3'b000, 1'b0, 0);
    run_instr(32'h00000000, 3'b000, 1'b0, 0);
    for (int k = 0; k < 10; k++) begin
      next_cycle();
      instr    = $urandom;
      halt_REQ = 1'($urandom_range(0, 1));
      {cmp_LTU, cmp_LT, cmp_EQ} = 3'($urandom_range(0, 7));
      expect_obs(base_obs());
    end

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain got=%0d entries expected=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Control FSM for the multicycle RV32I datapath. It decodes the latched instruction and drives every datapath and memory control strobe, one state per cycle.
- Sits beside the datapath. Consumes the instruction register and comparator flags. Produces reg_WE, rs1_SEL, rs2_SEL, reg_SEL, pc_SEL, imm_SEL, ALU_MODE, addrs_SEL, pc_EN, instr_EN, ALU_mem_EN, mem_in_EN, mem_WE and mem_MODE.
- Also counts retired instructions and supports a halt handshake.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- instr  in  32  instruction register contents; valid from EXEC onward.
- cmp_EQ  in  1  rs1 == rs2, from the datapath comparator.
- cmp_LT  in  1  rs1 < rs2, signed.
- cmp_LTU  in  1  rs1 < rs2, unsigned.
- halt_REQ  in  1  request to stop at the next instruction boundary.
- reg_WE, rs1_SEL, rs2_SEL, addrs_SEL, pc_EN, instr_EN, ALU_mem_EN, mem_in_EN, mem_WE  out  1 each  datapath/memory strobes.
- reg_SEL  out  2  register write source.
- pc_SEL  out  2  next-PC source.
- imm_SEL  out  3  immediate format.
- mem_MODE  out  3  memory access size.
- ALU_MODE  out  4  ALU operation.
- halted  out  1  FSM is parked in HALT.
- illegal_INSTR  out  1  sticky; undecodable opcode seen.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- Encodings:
  - rs1_SEL: 0 = rs1, 1 = PC.
  - rs2_SEL: 0 = rs2, 1 = immediate.
  - addrs_SEL: 1 = PC, 0 = ALU result.
  - reg_SEL: 00 = mem data, 01 = ALU, 10 = PC+4, 11 = immediate.
  - pc_SEL: 00 = PC+4, 01 = PC+imm, 10 = ALU result (low bit cleared in datapath), 11 = reserved (never driven).
  - imm_SEL: 000 = none, 001 = S, 010 = B, 011 = I, 100 = U, 101 = J.
  - ALU_MODE: 0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT, 0100 SLTU, 0101 XOR, 0110 SRL, 0111 SRA, 1000 OR, 1001 AND.
  - mem_MODE: funct3 for loads/stores; 010 for fetch.
- States: INIT, FETCH, EXEC, LOAD_WB, HALT, TRAP.
- Outputs are combinational from state plus instr. Don't-care fields are driven 0; X is never driven.
- Reset: state = INIT asynchronously; instret = 0; illegal_INSTR = 0. All strobes are 0 while reset is high and in INIT.
- INIT -> FETCH unconditionally.
- FETCH:
  - Drives addrs_SEL=1, instr_EN=1, mem_in_EN=1, mem_MODE=010.
  - All write enables and pc_EN are 0.
  - Goes to EXEC.
- EXEC, decode by opcode:
  - OP (0110011): rs1_SEL=0, rs2_SEL=0, reg_SEL=01, reg_WE=1. ALU_MODE from funct3, with funct7[5] selecting SUB/SRA.
  - OP-IMM (0010011): as OP but rs2_SEL=1 and imm_SEL=011. funct7[5] is honoured only for shifts.
  - LUI: reg_SEL=11, imm_SEL=100, reg_WE=1.
  - AUIPC: rs1_SEL=1, rs2_SEL=1, imm_SEL=100, ADD, reg_SEL=01, reg_WE=1.
  - JAL: reg_SEL=10, reg_WE=1, pc_SEL=01, imm_SEL=101.
  - JALR: reg_SEL=10, reg_WE=1, rs2_SEL=1, imm_SEL=011, ADD, pc_SEL=10.
  - BRANCH:
    - imm_SEL=010.
    - taken = funct3-selected EQ/NE/LT/GE/LTU/GEU from the cmp flags.
    - pc_SEL=01 if taken, else 00.
  - STORE: rs2_SEL=1, imm_SEL=001, ADD, addrs_SEL=0, ALU_mem_EN=1, mem_WE=1, mem_MODE=funct3.
  - LOAD:
    - rs2_SEL=1, imm_SEL=011, ADD, addrs_SEL=0, ALU_mem_EN=1, mem_in_EN=1, mem_MODE=funct3.
    - pc_EN=0 in EXEC; goes to LOAD_WB.
  - All non-load legal ops: pc_EN=1, retire.
  - Other opcode: all strobes 0, illegal_INSTR set, goes to TRAP.
- LOAD_WB: reg_SEL=00, reg_WE=1, pc_EN=1, pc_SEL=00; retire.
- Retire: instret increments by 1, wrapping at 2^CNT_W.
- After retire:
  - halt_REQ=1 -> HALT, else FETCH.
  - halt_REQ is sampled only at retire; mid-instruction assertion never truncates an instruction.
- HALT:
  - halted=1, all strobes 0.
  - Goes to FETCH on the first cycle halt_REQ=0.
- TRAP: absorbing, all strobes 0, illegal_INSTR=1; only reset exits.
- reset mid-EXEC/LOAD_WB: strobes drop to 0 immediately; no partial register or memory write on the following edge.
- Writes to x0 are the regfile's concern; the controller asserts reg_WE regardless.

Decomposition:
- Shared package bean_ctrl_pkg holds:
  - opcode constants;
  - state enum;
  - the reg_SEL, pc_SEL, imm_SEL, ALU_MODE and mem_MODE encodings, also used by the datapath.
- One sub-module, alu_decoder: combinational funct3/funct7[5]/opcode -> ALU_MODE.

Test Plan:
- Reset held 3 cycles, then released -> INIT one cycle; FETCH shows addrs_SEL=1, instr_EN=1, mem_in_EN=1, mem_MODE=010, reg_WE=0.
- instr=0x00800513 (addi x10,x0,8) in EXEC -> reg_WE=1, rs1_SEL=0, rs2_SEL=1, reg_SEL=01, imm_SEL=011, ALU_MODE=0000, pc_EN=1, pc_SEL=00; instret 0->1.
- instr=0x00b52023 (sw) -> imm_SEL=001, ALU_mem_EN=1, mem_WE=1, mem_MODE=010, reg_WE=0. Then instr=0x00452603 (lw) -> EXEC pc_EN=0, then LOAD_WB reg_SEL=00, reg_WE=1, pc_EN=1.
- instr=0x00000463 (beq) with cmp_EQ=1 -> pc_SEL=01, imm_SEL=010. Repeat with cmp_EQ=0 -> pc_SEL=00.
- instr=0x00000000 -> TRAP; illegal_INSTR=1 and all strobes 0 for 10 cycles; instret unchanged.
- halt_REQ raised during LOAD_WB -> HALT, halted=1; dropped -> FETCH next cycle. Reset asserted mid-EXEC of a store -> mem_WE=0 the same cycle.
